// File: rtl/spi_adc_mc_if.sv
// SPI pin bundle between a host (master) and the spi_adc_mc front end (slave).
interface spi_adc_mc_if;
    logic sclk;
    logic cs;
    logic mosi;
    logic miso;

    modport master (output sclk, output cs, output mosi, input miso);
    modport slave  (input sclk, input cs, input mosi, output miso);
endinterface

// File: rtl/spi_adc_mc.sv
// System-clocked SPI slave that selects one of N_CH ADC cores, programs a
// per-channel range field and returns the selected core's code on miso.
// All SPI pins are oversampled by clk; edges come from the synchronised copies.
module spi_adc_mc #(
    parameter int N_CH        = 4,
    parameter int CODE_W      = 10,
    parameter int RANGE_W     = 2,
    parameter int MODE        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    spi_adc_mc_if.slave               spi,
    input  logic [N_CH*CODE_W-1:0]    code_in,
    output logic [N_CH*RANGE_W-1:0]   range_o,
    output logic [((($clog2(N_CH)) > 1) ? $clog2(N_CH) : 1)-1:0] ch_sel,
    output logic                      sample,
    output logic                      frame_done,
    output logic                      cmd_err
);

    localparam int   CH_W    = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1;
    localparam int   CMD_W   = 1 + CH_W + RANGE_W;
    localparam int   CNT_W   = $clog2(CMD_W + 1);
    localparam int   FLUSH_W = $clog2(SYNC_STAGES + 2);
    localparam logic CPOL    = MODE[1];
    localparam logic CPHA    = MODE[0];

    typedef enum logic [1:0] {
        ST_ARM,    // after reset: wait until cs has genuinely been seen high
        ST_IDLE,   // deselected, waiting for cs to fall
        ST_FRAME   // frame in progress
    } state_t;

    // Synchronisers plus one history flop each for edge detection.
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_prev, cs_prev;
    logic [FLUSH_W-1:0]     flush_cnt;

    state_t state, state_next;

    logic do_start, do_finish, do_cap, do_shift;

    logic [CODE_W:0]   tx_sr;     // one extra guard bit for the CPHA=1 preload
    logic [CMD_W-1:0]  cmd_sr;
    logic [CNT_W-1:0]  bit_cnt;

    wire sclk_cur = sclk_sync[SYNC_STAGES-1];
    wire cs_cur   = cs_sync[SYNC_STAGES-1];
    wire mosi_cur = mosi_sync[SYNC_STAGES-1];

    wire sclk_chg = sclk_cur ^ sclk_prev;
    wire lead     = sclk_chg & (sclk_cur ^ CPOL);
    wire trail    = sclk_chg & ~(sclk_cur ^ CPOL);
    wire cs_fall  = cs_prev & ~cs_cur;
    wire cs_rise  = ~cs_prev & cs_cur;

    // Synchroniser chain contents only reflect the pins after it has flushed.
    wire flushed  = (flush_cnt == FLUSH_W'(SYNC_STAGES + 1));

    wire                cmd_wr   = cmd_sr[CMD_W-1];
    wire [CH_W-1:0]     cmd_ch   = cmd_sr[CMD_W-2 -: CH_W];
    wire [RANGE_W-1:0]  cmd_rng  = cmd_sr[RANGE_W-1:0];
    wire                cmd_full = (bit_cnt == CNT_W'(CMD_W));
    wire                ch_bad   = (32'(cmd_ch) >= N_CH);

    wire [CODE_W-1:0]   snap     = code_in[ch_sel*CODE_W +: CODE_W];

    // Pin synchronisers, reset to the idle bus levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= CPOL;
            cs_prev   <= 1'b1;
            flush_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so each stage takes the previous stage's old value.
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
            sclk_prev <= sclk_cur;
            cs_prev   <= cs_cur;
            if (!flushed) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_ARM;
        else        state <= state_next;
    end

    // Frame sequencing: cs edges win over sclk edges in the same clk.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        state_next = state;
        do_start   = 1'b0;
        do_finish  = 1'b0;
        do_cap     = 1'b0;
        do_shift   = 1'b0;
        case (state)
            ST_ARM: begin
                if (flushed && cs_cur) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    do_start   = 1'b1;
                    state_next = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (cs_rise) begin
                    do_finish  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    do_cap   = CPHA ? trail : lead;
                    do_shift = CPHA ? lead : trail;
                end
            end
            default: state_next = ST_ARM;
        endcase
    end

    // Shift registers, command decode and the registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr      <= '0;
            cmd_sr     <= '0;
            bit_cnt    <= '0;
            range_o    <= '0;
            ch_sel     <= '0;
            sample     <= 1'b0;
            frame_done <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            sample     <= do_start;
            frame_done <= 1'b0;
            cmd_err    <= 1'b0;

            if (do_start) begin
                // CPHA=0 presents the MSB now; CPHA=1 waits for the first leading edge.
                tx_sr   <= CPHA ? {1'b0, snap} : {snap, 1'b0};
                cmd_sr  <= '0;
                bit_cnt <= '0;
            end

            if (do_cap && !cmd_full) begin
                cmd_sr  <= {cmd_sr[CMD_W-2:0], mosi_cur};
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (do_shift) tx_sr <= {tx_sr[CODE_W-1:0], 1'b0};

            if (do_finish) begin
                tx_sr <= '0;
                if (!cmd_full || ch_bad) begin
                    cmd_err <= 1'b1;
                end else begin
                    ch_sel     <= cmd_ch;
                    frame_done <= 1'b1;
                    if (cmd_wr) range_o[cmd_ch*RANGE_W +: RANGE_W] <= cmd_rng;
                end
            end
        end
    end

    // miso is forced low whenever the synchronised cs is high or no frame is open.
    assign spi.miso = (state == ST_FRAME) && !cs_cur && tx_sr[CODE_W];

endmodule

// File: doc/spi_adc_mc.md
# spi_adc_mc

Parametrised multi-channel successor of the single-channel SPI ADC front end. It is a system-clocked SPI slave with oversampled `sclk`/`cs`/`mosi` and selectable SPI mode. It selects one of `N_CH` analog ADC cores, programs a per-channel range field, and returns the selected core's `CODE_W`-bit code on `miso`. It sits between the SPI pins and the SPICE-replaced `adc_core` instances, whose codes arrive flattened on `code_in`.

## Interface
- `N_CH`, 4: number of ADC channels (≥2).
- `CODE_W`, 10: ADC code width (4..16).
- `RANGE_W`, 2: range field width per channel (1..4).
- `MODE`, 0: SPI mode 0..3; CPOL=`MODE[1]`, CPHA=`MODE[0]`.
- `SYNC_STAGES`, 2: synchroniser depth on `sclk`, `cs`, `mosi` (≥2).
- Derived: `CH_W` = max(1, clog2(`N_CH`)); `CMD_W` = 1+`CH_W`+`RANGE_W`.

- `clk` in 1: system clock; requires f_clk ≥ 8×f_sclk.
- `rst_n` in 1: asynchronous, active-low reset.
- `sclk` in 1: SPI clock, asynchronous to `clk`.
- `cs` in 1: chip select, high = deselected.
- `mosi` in 1: SPI data in.
- `miso` out 1: SPI data out, MSB first.
- `code_in` in `N_CH*CODE_W`: channel k code at `[k*CODE_W +: CODE_W]`.
- `range_o` out `N_CH*RANGE_W`: channel k range at `[k*RANGE_W +: RANGE_W]`.
- `ch_sel` out `CH_W`: currently selected channel.
- `sample` out 1: 1-clk pulse when a frame starts; the code snapshot is taken.
- `frame_done` out 1: 1-clk pulse when a valid command is applied.
- `cmd_err` out 1: 1-clk pulse when a frame is short or its channel is out of range.

## Operation
- Reset values: `miso`=0, `range_o`=0, `ch_sel`=0, `sample`/`frame_done`/`cmd_err`=0, bit counter=0, shift registers=0.
- Synchronisers reset to idle: `cs`=1, `sclk`=CPOL.
- Leading edge = synced `sclk` leaving CPOL; trailing edge = returning to CPOL.

**Frame start** (synced `cs` falling):
- Snapshot `code_in` slice of current `ch_sel` into the MISO shift register.
- Clear the bit counter and pulse `sample`.

**MOSI capture:**
- Sample edge is leading for CPHA=0, trailing for CPHA=1.
- On each sample edge, shift `mosi` into the command register and increment the bit counter, saturating at `CMD_W`.
- Bits after the first `CMD_W` are ignored.

**MISO shift:**
- CPHA=0: MSB is driven at frame start; shift left on each trailing edge.
- CPHA=1: shift on each leading edge. The first leading edge presents the MSB; the register is preloaded as snapshot with one extra guard bit.
- After `CODE_W` bits, `miso`=0.
- `miso`=0 whenever synced `cs`=1.

**Command**, first `CMD_W` bits MSB first: {`wr`, `ch`[`CH_W`], `rng`[`RANGE_W`]}.

**Frame end** (synced `cs` rising):
- If bit count < `CMD_W`: pulse `cmd_err`; no update.
- If `ch` ≥ `N_CH`: pulse `cmd_err`; no update.
- Otherwise: `ch_sel` ← `ch`. If `wr`=1, `range_o[ch]` ← `rng`. Pulse `frame_done`.

**Pipelining:**
- The code returned in frame n is that of the channel selected at the end of frame n−1.
- The range written in frame n takes effect on the analog core after frame n.

**Boundary conditions:**
- `cs` rising and an `sclk` edge detected in the same clk: `cs` has priority; the `sclk` edge is dropped.
- `cs` falling and an `sclk` edge in the same clk: the frame starts; the `sclk` edge is dropped.
- `sclk` edges while `cs`=1 are ignored.
- Reset mid-frame: the frame is discarded with no update. If `cs`=0 at reset release, the block stays idle until `cs` has been seen high, then accepts the next falling edge.
- `N_CH` not a power of two: out-of-range `ch` values are rejected as above.

## Timing
- Edge detect compares the last two synchroniser stages. All actions register on the (`SYNC_STAGES`+1)-th rising `clk` edge after the pin transition.
- `miso` change lags the `sclk` shift edge by ≤ `SYNC_STAGES`+2 clk. The host must sample `miso` no earlier than that after its shift edge.
- `sample`, `frame_done`, `cmd_err`: exactly one clk high each.
- `ch_sel` and `range_o` update in the same clk as `frame_done`.
- Minimum `cs` high time: `SYNC_STAGES`+2 clk.

## Test plan
- **Reset then read:** `code_in` ch0=0x2A5, mode 0, 10-clock frame with MOSI=0b00000 → `miso` returns 1010100101, `ch_sel`=0, one `frame_done` pulse.
- **Write then read:** frame 1 MOSI=1_10_11 → `ch_sel`=2, `range_o`=0x30, `frame_done`. Frame 2 → `miso` returns the ch2 code 0x1F0; `range_o` unchanged.
- **Short frame:** 3 sclk cycles then `cs` high → `cmd_err` pulse, no `frame_done`, `ch_sel`/`range_o` unchanged.
- **All four modes:** with `code_in`=0x3C3, run one frame per MODE 0..3 → the same MSB-first code is received; the command is decoded identically.
- **Reset mid-frame:** `rst_n` pulsed after 3 bits with `cs` held low → all outputs 0. The next 5 bits are ignored until `cs` goes high; the following full frame is applied correctly.
- **Out-of-range channel:** `N_CH`=3, command ch=3 → `cmd_err`, no update. Simultaneous `cs` rise and `sclk` leading edge → no extra bit is counted.
